uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The module SHALL have parameter C_UART_DATA_WIDTH, default 8, the UART word width in bits.
REQ-002 The module SHALL have parameter C_REQ_COUNT, default 3, the number of requesters (2..8).
REQ-003 The module SHALL have parameter C_HOLD_TIMEOUT, default 1_000_000, the maximum number of idle clk cycles a message lock is held.
REQ-004 The module SHALL have port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The module SHALL have port reqValid, input, C_REQ_COUNT bits: per-requester word valid.
REQ-007 The module SHALL have port reqLast, input, C_REQ_COUNT bits: per-requester flag marking the word as the end of a message.
REQ-008 The module SHALL have port reqData, input, C_REQ_COUNT*C_UART_DATA_WIDTH bits: words, with requester i at bit slice [i*W +: W].
REQ-009 The module SHALL have port reqAck, output, C_REQ_COUNT bits: one-cycle accept pulse per requester.
REQ-010 The module SHALL have port reqErr, output, C_REQ_COUNT bits: txErr routed to the current owner only.
REQ-011 The module SHALL have port grant, output, C_REQ_COUNT bits: one-hot current owner, all-zero when no owner.
REQ-012 The module SHALL have port txBusy, input, 1 bit: UART_Tx busy.
REQ-013 The module SHALL have port txErr, input, 1 bit: UART_Tx error.
REQ-014 The module SHALL have port txSend, output, 1 bit: one-cycle send pulse to UART_Tx.
REQ-015 The module SHALL have port txData, output, C_UART_DATA_WIDTH bits: word to UART_Tx.

Function
REQ-016 The handshake SHALL work as follows: a requester holds reqValid, reqData and reqLast stable until reqAck; the word is latched on the reqAck cycle.
REQ-017 The FSM SHALL have exactly the states IDLE, SEND, WAIT_BUSY, WAIT_DONE and HOLD.
REQ-018 In IDLE with any reqValid high, the arbiter SHALL pick the winner round-robin, starting from the requester after the last owner, then assert reqAck for that winner, latch its data and last flag, set grant, and go to SEND, all on the same edge.
REQ-019 In SEND, txSend SHALL be 1 for exactly one cycle, after which the FSM goes to WAIT_BUSY.
REQ-020 Latency: reqValid sampled at edge N SHALL give txSend high during cycle N+1.
REQ-021 In WAIT_BUSY, the FSM SHALL wait for txBusy=1 and then go to WAIT_DONE.
REQ-022 In WAIT_DONE, on txBusy=0 the FSM SHALL go to IDLE if the latched last flag is 1 (clearing grant and advancing the pointer), otherwise to HOLD.
REQ-023 In HOLD, only the owner SHALL be accepted: its reqValid triggers an ack and latch and goes to SEND; all other requesters are stalled.
REQ-024 In HOLD, a 32-bit idle counter SHALL count cycles without owner reqValid; on reaching C_HOLD_TIMEOUT the FSM goes to IDLE, releases the lock and advances the pointer.
REQ-025 txData SHALL hold the latched word from SEND through WAIT_DONE.
REQ-026 reqErr[owner] SHALL equal txErr; all other reqErr bits SHALL be 0, and reqErr SHALL be all-zero when grant is 0.
REQ-027 A requester dropping reqValid before ack SHALL be legal; it is simply not selected.
REQ-028 reqValid from non-owners in states other than IDLE SHALL be ignored without an ack.
REQ-029 A single requester SHALL be served back-to-back with no starvation of others across messages.

Reset
REQ-030 On rst=1, the FSM SHALL go to IDLE, and txSend, reqAck, reqErr and grant SHALL be 0, txData SHALL be 0, the RR pointer SHALL point to requester 0 (so requester 0 has first priority), and the idle counter SHALL be 0.
REQ-031 Reset mid-message SHALL abort the message with no further txSend; release SHALL be synchronous to clk.

Structure
REQ-032 A shared package uart_arb_pkg SHALL hold the FSM state enumeration and the default parameter constants.
REQ-033 One sub-module, rr_picker, SHALL hold the combinational round-robin one-hot selection given the request vector and the pointer.
REQ-034 The total implementation size SHALL be 120-400 lines of RTL.

Verification
REQ-035 Scenario, single word: reqValid=001, reqLast=001, data 0x48 -> reqAck[0] pulse, txSend in the next cycle with txData=0x48, grant=001 until txBusy falls, then 000.
REQ-036 Scenario, simultaneous requests: reqValid=111 after reset, all last -> service order 0,1,2, then 0 again if it is still requesting.
REQ-037 Scenario, locked message: requester 1 sends "Hi!" with last only on '!' while requester 0 holds reqValid -> UART stream is 0x48,0x69,0x21 and only then requester 0's word.
REQ-038 Scenario, timeout: requester 2 sends one word with last=0, then goes silent with C_HOLD_TIMEOUT=16 -> HOLD lasts 16 cycles, the FSM returns to IDLE, and a pending requester 0 is served next.
REQ-039 Scenario, error routing: txErr=1 during a requester 1 transfer -> reqErr=010, and 000 in IDLE.
REQ-040 Scenario, reset mid-operation: rst asserted in WAIT_BUSY -> all outputs 0 immediately, and no txSend after release until a new reqValid.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, default
// parameter values and a small index helper.
package uart_arb_pkg;

    localparam int unsigned DEF_UART_DATA_WIDTH = 8;
    localparam int unsigned DEF_REQ_COUNT       = 3;
    localparam int unsigned DEF_HOLD_TIMEOUT    = 1_000_000;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE,
        HOLD
    } arb_state_e;

    // Next requester index in round-robin order, wrapping at n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin selector: first active request at or after ptr,
// returned both one-hot and as an index.
module rr_picker #(
    parameter int unsigned C_REQ_COUNT = 3,
    parameter int unsigned C_IDX_WIDTH = 2
) (
    input  logic [C_REQ_COUNT-1:0] req,
    input  logic [C_IDX_WIDTH-1:0] ptr,
    output logic [C_REQ_COUNT-1:0] gnt,
    output logic [C_IDX_WIDTH-1:0] gnt_idx,
    output logic                   any
);

    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int unsigned off = 0; off < C_REQ_COUNT; off++) begin
            idx = 32'(ptr) + off;
            if (idx >= C_REQ_COUNT) begin
                idx = idx - C_REQ_COUNT;
            end
            if (!any && req[idx]) begin
                any          = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = C_IDX_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between several requesters; a message (words up
// to and including the one flagged last) keeps the lock until done or idle timeout.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned C_UART_DATA_WIDTH = DEF_UART_DATA_WIDTH,
    parameter int unsigned C_REQ_COUNT       = DEF_REQ_COUNT,
    parameter int unsigned C_HOLD_TIMEOUT    = DEF_HOLD_TIMEOUT
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [C_REQ_COUNT-1:0]                   reqValid,
    input  logic [C_REQ_COUNT-1:0]                   reqLast,
    input  logic [C_REQ_COUNT*C_UART_DATA_WIDTH-1:0] reqData,
    output logic [C_REQ_COUNT-1:0]                   reqAck,
    output logic [C_REQ_COUNT-1:0]                   reqErr,
    output logic [C_REQ_COUNT-1:0]                   grant,
    input  logic                                     txBusy,
    input  logic                                     txErr,
    output logic                                     txSend,
    output logic [C_UART_DATA_WIDTH-1:0]             txData
);

    localparam int unsigned W  = C_UART_DATA_WIDTH;
    localparam int unsigned N  = C_REQ_COUNT;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    arb_state_e     state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [N-1:0]   ack_q, ack_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic           last_q, last_d;
    logic           tx_send_q, tx_send_d;
    logic [W-1:0]   tx_data_q, tx_data_d;
    logic [31:0]    idle_cnt_q, idle_cnt_d;

    logic [N-1:0]   pick_gnt;
    logic [IW-1:0]  pick_idx;
    logic           pick_any;
    logic [W-1:0]   pick_data;
    logic [W-1:0]   owner_data;
    logic [IW-1:0]  owner_next;

    rr_picker #(
        .C_REQ_COUNT (N),
        .C_IDX_WIDTH (IW)
    ) u_picker (
        .req     (reqValid),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign pick_data  = reqData[32'(pick_idx) * W +: W];
    assign owner_data = reqData[32'(owner_q) * W +: W];
    assign owner_next = IW'(wrap_inc(32'(owner_q), N));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        last_d     = last_q;
        tx_data_d  = tx_data_q;
        idle_cnt_d = idle_cnt_q;
        tx_send_d  = 1'b0;
        ack_d      = '0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    ack_d     = pick_gnt;
                    grant_d   = pick_gnt;
                    owner_d   = pick_idx;
                    tx_data_d = pick_data;
                    last_d    = reqLast[pick_idx];
                    tx_send_d = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (txBusy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!txBusy) begin
                    if (last_q) begin
                        state_d = IDLE;
                        grant_d = '0;
                        ptr_d   = owner_next;
                    end else begin
                        state_d    = HOLD;
                        idle_cnt_d = '0;
                    end
                end
            end
            HOLD: begin
                // Only the lock owner may continue; everyone else stalls.
                if (reqValid[owner_q]) begin
                    ack_d      = grant_q;
                    tx_data_d  = owner_data;
                    last_d     = reqLast[owner_q];
                    tx_send_d  = 1'b1;
                    idle_cnt_d = '0;
                    state_d    = SEND;
                end else if (idle_cnt_q + 32'd1 >= C_HOLD_TIMEOUT) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    ptr_d      = owner_next;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            last_q     <= 1'b0;
            tx_send_q  <= 1'b0;
            tx_data_q  <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            last_q     <= last_d;
            tx_send_q  <= tx_send_d;
            tx_data_q  <= tx_data_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign txSend = tx_send_q;
    assign txData = tx_data_q;
    assign reqAck = ack_q;
    assign grant  = grant_q;
    assign reqErr = grant_q & {N{txErr}};

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requester queues feed the DUT,
// a monitor checks every txSend against the expected word/owner queue.
module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int TO = 16;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] grant;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   reqValid = '0;
    logic [2:0]   reqLast = '0;
    logic [23:0]  reqData = '0;
    logic [2:0]   reqAck;
    logic [2:0]   reqErr;
    logic [2:0]   grant;
    logic         txBusy = 1'b0;
    logic         txErr = 1'b0;
    logic         txSend;
    logic [7:0]   txData;

    int           checks = 0;
    int           failures = 0;
    exp_t         exp_q[$];
    exp_t         e;
    logic [8:0]   rq[3][$];
    int           busy_cnt = 0;
    int           send_count = 0;
    logic         prev_send = 1'b0;
    logic         hold_mon = 1'b0;
    int           hold_low_cycles = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .C_UART_DATA_WIDTH (W),
        .C_REQ_COUNT       (N),
        .C_HOLD_TIMEOUT    (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .reqValid (reqValid),
        .reqLast  (reqLast),
        .reqData  (reqData),
        .reqAck   (reqAck),
        .reqErr   (reqErr),
        .grant    (grant),
        .txBusy   (txBusy),
        .txErr    (txErr),
        .txSend   (txSend),
        .txData   (txData)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l, input logic sb);
        rq[r].push_back({l, d});
        if (sb) exp_q.push_back('{data: d, grant: 3'(1 << r)});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || rq[0].size() != 0 || rq[1].size() != 0 ||
                rq[2].size() != 0 || grant != 3'b000) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 32'(n < budget), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) rq[i].delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Requester BFMs plus a UART model: busy for 4 cycles after each send.
    always @(posedge clk) begin
        logic [8:0] head;
        #1;
        if (rst) busy_cnt = 0;
        else if (txSend) busy_cnt = 4;
        else if (busy_cnt > 0) busy_cnt--;
        txBusy = (busy_cnt > 0);
        for (int i = 0; i < N; i++) begin
            if (reqAck[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (rq[i].size() > 0) begin
                head = rq[i][0];
                reqValid[i]       = 1'b1;
                reqLast[i]        = head[8];
                reqData[i*W +: W] = head[7:0];
            end else begin
                reqValid[i]       = 1'b0;
                reqLast[i]        = 1'b0;
                reqData[i*W +: W] = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_send) check("send_one_cycle", 32'(txSend), 32'd0);
            if (txSend) begin
                send_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_send: got txData 0x%0h grant %b, expected no send", txData, grant);
                end else begin
                    e = exp_q.pop_front();
                    check("txData", 32'(txData), 32'(e.data));
                    check("grant_at_send", 32'(grant), 32'(e.grant));
                    check("ack_at_send", 32'(reqAck), 32'(e.grant));
                end
            end
            if (hold_mon && grant == 3'b100 && !txBusy) hold_low_cycles++;
        end
        prev_send = rst ? 1'b0 : txSend;
    end

    initial begin
        int n;
        int sends_before;

        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_txSend", 32'(txSend), 32'd0);
        check("rst_reqAck", 32'(reqAck), 32'd0);
        check("rst_reqErr", 32'(reqErr), 32'd0);
        check("rst_txData", 32'(txData), 32'd0);
        rst = 1'b0;

        // Single word from requester 0; grant held until busy falls.
        push(0, 8'h48, 1'b1, 1'b1);
        n = 0;
        while (!txBusy && n < 50) begin @(negedge clk); n++; end
        check("single_busy_seen", 32'(n < 50), 32'd1);
        n = 0;
        while (txBusy && n < 50) begin @(negedge clk); n++; end
        check("single_grant_at_busy_fall", 32'(grant), 32'b001);
        @(negedge clk);
        check("single_grant_released", 32'(grant), 32'b000);
        wait_drain("single", 100);

        // All three at once after reset: order 0,1,2 then 0 again.
        do_reset();
        push(0, 8'hA0, 1'b1, 1'b1);
        push(1, 8'hB1, 1'b1, 1'b1);
        push(2, 8'hC2, 1'b1, 1'b1);
        push(0, 8'hA1, 1'b1, 1'b1);
        wait_drain("round_robin", 300);

        // Locked message "Hi!" from 1 while 0 waits; pointer is at 1 here.
        push(1, 8'h48, 1'b0, 1'b1);
        push(1, 8'h69, 1'b0, 1'b1);
        push(1, 8'h21, 1'b1, 1'b1);
        push(0, 8'h55, 1'b1, 1'b1);
        wait_drain("locked_msg", 300);

        // Error routing to the owner only.
        push(1, 8'h3C, 1'b1, 1'b1);
        n = 0;
        while (!(txBusy && grant == 3'b010) && n < 50) begin @(negedge clk); n++; end
        check("err_busy_seen", 32'(n < 50), 32'd1);
        txErr = 1'b1;
        #1;
        check("err_routed_owner", 32'(reqErr), 32'b010);
        n = 0;
        while (grant != 3'b000 && n < 50) begin @(negedge clk); n++; end
        check("err_grant_released", 32'(n < 50), 32'd1);
        check("err_zero_in_idle", 32'(reqErr), 32'b000);
        txErr = 1'b0;
        wait_drain("err", 100);

        // Timeout: 2 sends a non-last word and goes silent; 0 waits behind it.
        hold_low_cycles = 0;
        hold_mon = 1'b1;
        push(2, 8'hA5, 1'b0, 1'b1);
        n = 0;
        while (grant != 3'b100 && n < 50) begin @(negedge clk); n++; end
        check("timeout_grant_seen", 32'(n < 50), 32'd1);
        push(0, 8'h33, 1'b1, 1'b1);
        wait_drain("timeout", 300);
        hold_mon = 1'b0;
        // One WAIT_DONE cycle with busy low, then TO cycles in HOLD.
        check("hold_cycles", 32'(hold_low_cycles), 32'(TO + 1));

        // Reset while waiting for busy aborts with no further send.
        push(1, 8'h5A, 1'b1, 1'b1);
        n = 0;
        while (!txSend && n < 50) begin @(negedge clk); n++; end
        check("abort_send_seen", 32'(n < 50), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_grant", 32'(grant), 32'd0);
        check("abort_txSend", 32'(txSend), 32'd0);
        check("abort_reqAck", 32'(reqAck), 32'd0);
        check("abort_reqErr", 32'(reqErr), 32'd0);
        check("abort_txData", 32'(txData), 32'd0);
        for (int i = 0; i < N; i++) rq[i].delete();
        exp_q.delete();
        sends_before = send_count;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_send", 32'(send_count), 32'(sends_before));
        push(2, 8'h7E, 1'b1, 1'b1);
        wait_drain("after_abort", 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
